// File: rtl/md_unit.sv
// Multiply/divide unit holding HI/LO. One operation is in flight at a time;
// the result lands in HI/LO on the last run cycle. Divide by zero runs the
// full count but leaves HI/LO untouched.
//
// state  | meaning
// S_IDLE | cnt == 0, accepts start or mthi/mtlo
// S_RUN  | cnt != 0, counting down to commit
module md_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hiWE,
  input  logic        loWE,
  input  logic        mdsel,
  output logic        busy,
  output logic [31:0] out
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [1:0]  op;
  logic [31:0] op_a, op_b;
  logic [31:0] hi, lo;
  logic        accept, commit, mt_ok, div_by_zero;

  logic [63:0] mul_a, mul_b, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, uquo, urem, quo, rem;

  // op[1] selects divide, op[0] selects unsigned
  assign accept      = start && (state == S_IDLE) && !md_op[2];
  assign mt_ok       = !busy && !start;
  assign div_by_zero = op[1] && (op_b == 32'd0);
  assign out         = mdsel ? hi : lo;

  // Product and quotient from the latched operands; signed divide works on
  // magnitudes so truncation toward zero falls out of the unsigned divider.
  always_comb begin
    mul_a = op[0] ? {32'd0, op_a} : {{32{op_a[31]}}, op_a};
    mul_b = op[0] ? {32'd0, op_b} : {{32{op_b[31]}}, op_b};
    prod  = mul_a * mul_b;
    neg_a = !op[0] && op_a[31];
    neg_b = !op[0] && op_b[31];
    mag_a = neg_a ? (32'd0 - op_a) : op_a;
    mag_b = neg_b ? (32'd0 - op_b) : op_b;
    uquo  = 32'd0;
    urem  = 32'd0;
    if (mag_b != 32'd0) begin
      uquo = mag_a / mag_b;
      urem = mag_a % mag_b;
    end
    quo = (neg_a ^ neg_b) ? (32'd0 - uquo) : uquo;
    rem = neg_a ? (32'd0 - urem) : urem;
  end

  // Next-state and countdown
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_RUN;
          cnt_next   = md_op[1] ? DIV_CYCLES : MUL_CYCLES;
        end
      end
      S_RUN: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          commit     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // State register, counter and registered busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      busy  <= (cnt_next != 4'd0);
    end
  end

  // Operand latch on accept; later A/B changes cannot reach the result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op   <= 2'd0;
      op_a <= 32'd0;
      op_b <= 32'd0;
    end else if (accept) begin
      op   <= md_op[1:0];
      op_a <= A;
      op_b <= B;
    end
  end

  // HI/LO: result commit, otherwise mthi/mtlo while idle with no start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (commit) begin
      if (!div_by_zero) begin
        hi <= op[1] ? rem : prod[63:32];
        lo <= op[1] ? quo : prod[31:0];
      end
    end else if (mt_ok) begin
      if (hiWE) hi <= A;
      if (loWE) lo <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Randomized and directed checks of md_unit against a 64-bit arithmetic model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        hiWE, loWE, mdsel;
  logic        busy;
  logic [31:0] out;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi, m_lo;

  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .hiWE(hiWE), .loWE(loWE), .mdsel(mdsel), .busy(busy), .out(out)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the operand values.
  function automatic void model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p, q, r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      3'd3: if (b != 0) begin q = ua / ub; r = ua % ub; m_lo = q[31:0]; m_hi = r[31:0]; end
      default: ;
    endcase
  endfunction

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    mdsel = 1'b1; #1; h = out;
    mdsel = 1'b0; #1; l = out;
  endtask

  task automatic do_mt(input logic hw, input logic lw, input logic [31:0] v);
    @(negedge clk); hiWE = hw; loWE = lw; A = v;
    @(negedge clk); hiWE = 1'b0; loWE = 1'b0;
    if (hw) m_hi = v;
    if (lw) m_lo = v;
  endtask

  // Issue one op, scramble A/B afterwards, count busy cycles, watch out stays put.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output bit held);
    logic [31:0] pre;
    @(negedge clk); start = 1'b1; md_op = op; A = a; B = b;
    @(negedge clk); start = 1'b0; A = $urandom; B = $urandom;
    #1; pre = out; held = 1'b1; cyc = 0;
    while (busy && cyc < 20) begin
      cyc++;
      if (out !== pre) held = 1'b0;
      @(negedge clk); A = $urandom; B = $urandom;
    end
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    reset = 1'b0; start = 1'b0; md_op = 3'd0; A = '0; B = '0;
    hiWE = 1'b0; loWE = 1'b0; mdsel = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    read_hilo(h, l);
    checks++; if (h !== 32'd0 || l !== 32'd0) begin errors++; $display("FAIL reset_hilo got=%h/%h exp=0/0", h, l); end
    m_hi = 0; m_lo = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult_vectors();
    int cyc; bit held; logic [31:0] h, l;
    run_op(3'd0, 32'hFFFFFFFE, 32'd3, cyc, held); model_op(3'd0, 32'hFFFFFFFE, 32'd3);
    read_hilo(h, l);
    checks++; if (cyc != 5) begin errors++; $display("FAIL mult_latency got=%0d exp=5", cyc); end
    checks++; if (!held) begin errors++; $display("FAIL mult_hold got=changed exp=held"); end
    checks++; if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_neg got=%h/%h exp=ffffffff/fffffffa", h, l); end
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, held); model_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    read_hilo(h, l);
    checks++; if (cyc != 5) begin errors++; $display("FAIL multu_latency got=%0d exp=5", cyc); end
    checks++; if (h !== 32'hFFFFFFFE || l !== 32'h00000001) begin errors++; $display("FAIL multu_max got=%h/%h exp=fffffffe/00000001", h, l); end
  endtask

  task automatic test_div();
    int cyc; bit held; logic [31:0] h, l;
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, cyc, held); model_op(3'd2, 32'hFFFFFFF9, 32'd2);
    read_hilo(h, l);
    checks++; if (cyc != 10) begin errors++; $display("FAIL div_latency got=%0d exp=10", cyc); end
    checks++; if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg got=%h/%h exp=ffffffff/fffffffd", h, l); end
    do_mt(1'b1, 1'b0, 32'h11);
    do_mt(1'b0, 1'b1, 32'h22);
    run_op(3'd3, 32'd7, 32'd0, cyc, held);
    read_hilo(h, l);
    checks++; if (cyc != 10) begin errors++; $display("FAIL divz_latency got=%0d exp=10", cyc); end
    checks++; if (h !== 32'h11 || l !== 32'h22) begin errors++; $display("FAIL div_by_zero got=%h/%h exp=00000011/00000022", h, l); end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, cyc, held); model_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    read_hilo(h, l);
    checks++; if (h !== 32'h0 || l !== 32'h80000000) begin errors++; $display("FAIL div_overflow got=%h/%h exp=00000000/80000000", h, l); end
  endtask

  task automatic test_mt();
    int cyc; logic [31:0] h, l, a, b;
    do_mt(1'b1, 1'b0, 32'h12345678);
    mdsel = 1'b1; #1;
    checks++; if (out !== 32'h12345678) begin errors++; $display("FAIL mthi got=%h exp=12345678", out); end
    do_mt(1'b1, 1'b1, 32'hCAFEF00D);
    read_hilo(h, l);
    checks++; if (h !== 32'hCAFEF00D || l !== 32'hCAFEF00D) begin errors++; $display("FAIL mt_both got=%h/%h exp=cafef00d/cafef00d", h, l); end
    // mtlo while busy is dropped
    a = $urandom; b = $urandom;
    @(negedge clk); start = 1'b1; md_op = 3'd1; A = a; B = b;
    @(negedge clk); start = 1'b0; loWE = 1'b1; A = 32'hDEADBEEF;
    @(negedge clk); loWE = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin cyc++; @(negedge clk); end
    model_op(3'd1, a, b);
    read_hilo(h, l);
    checks++; if (l !== m_lo || h !== m_hi) begin errors++; $display("FAIL mtlo_busy got=%h/%h exp=%h/%h", h, l, m_hi, m_lo); end
    // start and mtlo on the same edge: only the result lands
    a = $urandom; b = $urandom;
    @(negedge clk); start = 1'b1; loWE = 1'b1; md_op = 3'd0; A = a; B = b;
    @(negedge clk); start = 1'b0; loWE = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin cyc++; @(negedge clk); end
    model_op(3'd0, a, b);
    read_hilo(h, l);
    checks++; if (cyc != 5 || l !== m_lo || h !== m_hi) begin errors++; $display("FAIL start_mtlo got=%0d:%h/%h exp=5:%h/%h", cyc, h, l, m_hi, m_lo); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic [31:0] h, l, a, b;
    a = $urandom; b = $urandom_range(1, 1000);
    @(negedge clk); start = 1'b1; md_op = 3'd2; A = a; B = b;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (busy && cyc < 30) begin
      cyc++;
      if (cyc == 3) begin start = 1'b1; md_op = 3'd0; A = $urandom; B = $urandom; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    model_op(3'd2, a, b);
    read_hilo(h, l);
    checks++; if (cyc != 10) begin errors++; $display("FAIL b2b_latency got=%0d exp=10", cyc); end
    checks++; if (h !== m_hi || l !== m_lo) begin errors++; $display("FAIL b2b_result got=%h/%h exp=%h/%h", h, l, m_hi, m_lo); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_restart got=%b exp=0", busy); end
  endtask

  task automatic test_reserved();
    logic [31:0] h, l;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start = 1'b1; md_op = 3'(4 + i); A = $urandom; B = $urandom;
      @(negedge clk); start = 1'b0; #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reserved_busy op=%0d got=%b exp=0", 4 + i, busy); end
    end
    read_hilo(h, l);
    checks++; if (h !== m_hi || l !== m_lo) begin errors++; $display("FAIL reserved_hilo got=%h/%h exp=%h/%h", h, l, m_hi, m_lo); end
  endtask

  task automatic test_reset_midop();
    int cyc; logic [31:0] h, l, a, b;
    @(negedge clk); start = 1'b1; md_op = 3'd2; A = $urandom; B = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    read_hilo(h, l);
    checks++; if (h !== 32'd0 || l !== 32'd0) begin errors++; $display("FAIL midreset_hilo got=%h/%h exp=0/0", h, l); end
    m_hi = 0; m_lo = 0;
    a = $urandom; b = $urandom;
    @(negedge clk); reset = 1'b1; start = 1'b1; md_op = 3'd0; A = a; B = b;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin cyc++; @(negedge clk); end
    model_op(3'd0, a, b);
    read_hilo(h, l);
    checks++; if (cyc != 5 || h !== m_hi || l !== m_lo) begin errors++; $display("FAIL post_reset_mult got=%0d:%h/%h exp=5:%h/%h", cyc, h, l, m_hi, m_lo); end
  endtask

  task automatic test_random();
    int cyc; bit held; logic [31:0] h, l, a, b; logic [2:0] op; int exp_cyc;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 16);
        2: b = 32'd0 - $urandom_range(1, 16);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) do_mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      mdsel = 1'($urandom_range(0, 1));
      run_op(op, a, b, cyc, held);
      model_op(op, a, b);
      exp_cyc = op[1] ? 10 : 5;
      read_hilo(h, l);
      checks++; if (cyc != exp_cyc) begin errors++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", op, cyc, exp_cyc); end
      checks++; if (!held) begin errors++; $display("FAIL rand_hold op=%0d got=changed exp=held", op); end
      checks++; if (h !== m_hi || l !== m_lo) begin errors++; $display("FAIL rand_result op=%0d a=%h b=%h got=%h/%h exp=%h/%h", op, a, b, h, l, m_hi, m_lo); end
    end
  endtask

  initial begin
    test_reset();
    test_mult_vectors();
    test_div();
    test_mt();
    test_back_to_back();
    test_reserved();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
REQ-003 start  input  1  one-cycle request to begin operation md_op on A, B.
REQ-004 md_op  input  3  000 mult, 001 multu, 010 div, 011 divu; 100-111 reserved.
REQ-005 A  input  32  operand rs (dividend / multiplicand); also write data for hiWE/loWE.
REQ-006 B  input  32  operand rt (divisor / multiplier).
REQ-007 hiWE  input  1  mthi: write A to HI.
REQ-008 loWE  input  1  mtlo: write A to LO.
REQ-009 mdsel  input  1  read select: 1 = HI, 0 = LO.
REQ-010 busy  output  1  registered; 1 while an operation is in flight.
REQ-011 out  output  32  combinational read of HI (mdsel=1) or LO (mdsel=0).

Function
REQ-012 State: HI[31:0], LO[31:0], cnt[3:0], latched op[1:0], latched operands opA/opB[31:0].
REQ-013 Two states: IDLE (cnt=0, busy=0), RUN (cnt!=0, busy=1); busy = (cnt!=0), registered.
REQ-014 Accept: start=1, busy=0, md_op in 000-011 at edge k -> latch md_op, A, B; cnt loaded with 5 (mult/multu) or 10 (div/divu).
REQ-015 RUN: cnt decrements each edge; at the edge where cnt==1, commit result to HI/LO and cnt becomes 0.
REQ-016 Latency: busy=1 for exactly 5 (mult) / 10 (div) cycles after accept edge; new HI/LO visible on out in the cycle busy first reads 0.
REQ-017 mult: {HI,LO} = signed 64-bit product; multu: unsigned 64-bit product.
REQ-018 div: LO = quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-019 Signed overflow div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
REQ-020 Divide by zero (opB=0, div or divu): operation runs full 10 cycles, HI and LO left unchanged.
REQ-021 start while busy=1 ignored; running op and its operands unaffected.
REQ-022 start with reserved md_op (100-111) ignored; stays IDLE.
REQ-023 hiWE/loWE applied at edge only when busy=0 and start=0; ignored otherwise (no effect on in-flight result).
REQ-024 hiWE and loWE both 1: HI and LO both take A.
REQ-025 start and hiWE/loWE same edge while idle: start wins, mt* write dropped.
REQ-026 HI/LO hold value during RUN until commit; out reflects pre-operation values while busy=1.
REQ-027 Operand changes on A/B after accept edge have no effect on result.
REQ-028 Pipeline contract: decoder stalls any mf*/mt*/md instruction in D while (start|busy) in E; unit does not rely on this for correctness.

Reset
REQ-029 reset=0: HI=0, LO=0, cnt=0, busy=0, latched op/operands=0, out=0, asynchronously.
REQ-030 reset asserted mid-operation aborts it; no commit occurs; after release unit is IDLE and accepts start on the next edge.

Verification
REQ-031 mult A=0xFFFFFFFE (-2), B=3, start 1 cycle -> busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 with HI=0x11, LO=0x22 -> unchanged after 10 cycles.
REQ-034 mthi A=0x12345678 idle -> next cycle mdsel=1 out=0x12345678; mtlo during busy -> LO unchanged; start+mtlo same edge -> only op result lands.
REQ-035 div started, second start (mult) at cycle 3 -> ignored, busy still falls after cycle 10, div result only.
REQ-036 reset pulsed low at cycle 4 of div -> busy=0, HI=LO=0 immediately; mult issued next edge after release completes normally in 5 cycles.
